modexp_core: RTL and testbench

Parametrised modular exponentiation engine computing `result = message^exponent mod modulus` with a bit-serial interleaved (Blakley) modular multiplier and left-to-right square-and-multiply. It is the next-generation core behind the RSA datapath: operand width and exponent width are independent parameters, and the block adds a start/busy/done handshake, abort, error reporting and an optional constant-time mode. One instance serves encrypt or decrypt; the caller selects the exponent.

---
 rtl/modexp_core_if.sv | 26 ++
 rtl/modexp_core.sv | 162 ++++++++++++++++
 tb/tb_modexp_core.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/modexp_core_if.sv
// Request/response bundle for modexp_core: start/abort with operands in,
// busy/done/error/result out.
interface modexp_core_if #(
    parameter int WIDTH     = 4096,
    parameter int EXP_WIDTH = 4096
);
    logic                 start;
    logic                 abort;
    logic [WIDTH-1:0]     message;
    logic [EXP_WIDTH-1:0] exponent;
    logic [WIDTH-1:0]     modulus;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [WIDTH-1:0]     result;

    modport master (
        output start, abort, message, exponent, modulus,
        input  busy, done, error, result
    );

    modport slave (
        input  start, abort, message, exponent, modulus,
        output busy, done, error, result
    );
endinterface

// File: rtl/modexp_core.sv
// Modular exponentiation message^exponent mod modulus: left-to-right
// square-and-multiply over a bit-serial interleaved (Blakley) multiplier.
module modexp_core #(
    parameter int WIDTH      = 4096,
    parameter int EXP_WIDTH  = 4096,
    parameter bit CONST_TIME = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    modexp_core_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int EW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam int PW = WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REDUCE,
        S_SQR,
        S_MUL,
        S_FIN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0]     r_msg;
    logic [WIDTH-1:0]     r_mod;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [WIDTH-1:0]     r_r;
    logic [WIDTH-1:0]     r_x;
    logic [PW-1:0]        r_p;
    logic [CW-1:0]        r_cnt;
    logic [EW-1:0]        r_bit;
    logic                 r_err;
    logic                 r_done;
    logic                 r_error;
    logic [WIDTH-1:0]     r_result;

    logic             w_last;
    logic             w_ebit;
    logic             w_abort;
    logic             w_a_bit;
    logic             w_busy;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [PW-1:0]    w_m;
    logic [PW-1:0]    w_p2;
    logic [PW-1:0]    w_s1;
    logic [PW-1:0]    w_s2;

    // One multiplier iteration: P = 2P + a_i*B, then at most two subtractions of M.
    always_comb begin
        w_last  = (r_cnt == '0);
        w_ebit  = r_exp[r_bit];
        w_abort = bus.abort && (r_state != S_IDLE);
        w_a     = (r_state == S_REDUCE) ? r_msg : r_r;
        w_b     = (r_state == S_MUL) ? r_x : r_r;
        w_a_bit = w_a[r_cnt];
        w_m     = {2'b00, r_mod};
        w_p2    = (r_p << 1) + (w_a_bit ? {2'b00, w_b} : '0);
        w_s1    = (w_p2 >= w_m) ? (w_p2 - w_m) : w_p2;
        w_s2    = (w_s1 >= w_m) ? (w_s1 - w_m) : w_s1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (bus.start) w_next = S_LOAD;
                S_LOAD:   w_next = (r_mod == '0) ? S_FIN : S_REDUCE;
                S_REDUCE: if (w_last) w_next = S_SQR;
                S_SQR: begin
                    // Skipping the multiply re-enters SQR for the next bit.
                    if (w_last) begin
                        if (CONST_TIME || w_ebit) w_next = S_MUL;
                        else if (r_bit == '0)     w_next = S_FIN;
                    end
                end
                S_MUL:    if (w_last) w_next = (r_bit == '0) ? S_FIN : S_SQR;
                S_FIN:    w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy     = (r_state != S_IDLE);
        bus.busy   = w_busy;
        bus.done   = r_done;
        bus.error  = r_error;
        bus.result = r_result;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_msg    <= '0;
            r_mod    <= '0;
            r_exp    <= '0;
            r_r      <= '0;
            r_x      <= '0;
            r_p      <= '0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_msg <= bus.message;
                        r_mod <= bus.modulus;
                        r_exp <= bus.exponent;
                        r_bit <= EW'(EXP_WIDTH - 1);
                    end
                end
                S_LOAD: begin
                    r_err <= (r_mod == '0);
                    r_r   <= (r_mod == WIDTH'(1)) ? '0 : WIDTH'(1);
                    r_p   <= '0;
                    r_cnt <= CW'(WIDTH - 1);
                end
                S_REDUCE, S_SQR, S_MUL: begin
                    if (!w_last) begin
                        r_p   <= w_s2;
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_p   <= '0;
                        r_cnt <= CW'(WIDTH - 1);
                        if (r_state == S_REDUCE)     r_x <= w_s2[WIDTH-1:0];
                        else if (r_state == S_SQR)   r_r <= w_s2[WIDTH-1:0];
                        else if (w_ebit)             r_r <= w_s2[WIDTH-1:0];
                        if (r_state == S_MUL || (r_state == S_SQR && !CONST_TIME && !w_ebit))
                            r_bit <= r_bit - 1'b1;
                    end
                end
                S_FIN: begin
                    if (!bus.abort) begin
                        r_done   <= 1'b1;
                        r_error  <= r_err;
                        r_result <= r_err ? '0 : r_r;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_modexp_core.sv
// Bench for modexp_core: 8-bit constant-time, 8-bit variable-time and 64-bit
// constant-time instances, checked every cycle against a transaction-level model.
module tb_modexp_core;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        s_start [3];
    logic        s_abort [3];
    logic [63:0] s_msg   [3];
    logic [63:0] s_exp   [3];
    logic [63:0] s_mod   [3];
    logic        o_busy  [3];
    logic        o_done  [3];
    logic        o_err   [3];
    logic [63:0] o_res   [3];

    modexp_core_if #(.WIDTH(8),  .EXP_WIDTH(8))  b0 ();
    modexp_core_if #(.WIDTH(8),  .EXP_WIDTH(8))  b1 ();
    modexp_core_if #(.WIDTH(64), .EXP_WIDTH(64)) b2 ();

    modexp_core #(.WIDTH(8),  .EXP_WIDTH(8),  .CONST_TIME(1'b1)) u_ct8  (.clk(clk), .reset(rst_n), .bus(b0));
    modexp_core #(.WIDTH(8),  .EXP_WIDTH(8),  .CONST_TIME(1'b0)) u_vt8  (.clk(clk), .reset(rst_n), .bus(b1));
    modexp_core #(.WIDTH(64), .EXP_WIDTH(64), .CONST_TIME(1'b1)) u_ct64 (.clk(clk), .reset(rst_n), .bus(b2));

    assign b0.start = s_start[0];  assign b0.abort = s_abort[0];
    assign b0.message = s_msg[0][7:0];  assign b0.exponent = s_exp[0][7:0];  assign b0.modulus = s_mod[0][7:0];
    assign b1.start = s_start[1];  assign b1.abort = s_abort[1];
    assign b1.message = s_msg[1][7:0];  assign b1.exponent = s_exp[1][7:0];  assign b1.modulus = s_mod[1][7:0];
    assign b2.start = s_start[2];  assign b2.abort = s_abort[2];
    assign b2.message = s_msg[2];  assign b2.exponent = s_exp[2];  assign b2.modulus = s_mod[2];

    assign o_busy[0] = b0.busy;  assign o_done[0] = b0.done;  assign o_err[0] = b0.error;
    assign o_res[0]  = {56'd0, b0.result};
    assign o_busy[1] = b1.busy;  assign o_done[1] = b1.done;  assign o_err[1] = b1.error;
    assign o_res[1]  = {56'd0, b1.result};
    assign o_busy[2] = b2.busy;  assign o_done[2] = b2.done;  assign o_err[2] = b2.error;
    assign o_res[2]  = b2.result;

    function automatic int wid(input int d);
        return (d == 2) ? 64 : 8;
    endfunction

    function automatic bit ct(input int d);
        return d != 1;
    endfunction

    function automatic logic [63:0] msk(input int d, input logic [63:0] v);
        return (d == 2) ? v : (v & 64'hff);
    endfunction

    function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b, input logic [63:0] m);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        return 64'(p % {64'd0, m});
    endfunction

    // Right-to-left binary powering with plain arithmetic.
    function automatic logic [63:0] ref_pow(input logic [63:0] base, input logic [63:0] e,
                                            input logic [63:0] m, input int ew);
        logic [63:0] r;
        logic [63:0] x;
        if (m == 64'd0) return 64'd0;
        r = 64'd1 % m;
        x = base % m;
        for (int i = 0; i < ew; i++) begin
            if (e[i]) r = mulmod(r, x, m);
            x = mulmod(x, x, m);
        end
        return r;
    endfunction

    function automatic int ref_lat(input int d, input logic [63:0] e, input logic [63:0] m);
        int w;
        w = wid(d);
        if (m == 64'd0) return 2;
        return 2 + w + (ct(d) ? 2 * w : w + $countones(e)) * w;
    endfunction

    task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    bit          m_busy [3];
    bit          m_done [3];
    bit          m_err  [3];
    logic [63:0] m_res  [3];
    int          m_cnt  [3];
    bit          m_nerr [3];
    logic [63:0] m_nres [3];

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                m_busy[d] = 1'b0;  m_done[d] = 1'b0;  m_err[d] = 1'b0;
                m_res[d]  = 64'd0; m_cnt[d]  = 0;
            end else begin
                m_done[d] = 1'b0;
                if (m_busy[d]) begin
                    if (s_abort[d]) begin
                        m_busy[d] = 1'b0;
                    end else begin
                        m_cnt[d]--;
                        if (m_cnt[d] == 0) begin
                            m_busy[d] = 1'b0;
                            m_done[d] = 1'b1;
                            m_res[d]  = m_nres[d];
                            m_err[d]  = m_nerr[d];
                        end
                    end
                end else if (s_start[d]) begin
                    m_busy[d] = 1'b1;
                    m_cnt[d]  = ref_lat(d, msk(d, s_exp[d]), msk(d, s_mod[d]));
                    m_nerr[d] = (msk(d, s_mod[d]) == 64'd0);
                    m_nres[d] = ref_pow(msk(d, s_msg[d]), msk(d, s_exp[d]), msk(d, s_mod[d]), wid(d));
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            check("busy",   d, 64'(o_busy[d]), 64'(m_busy[d]));
            check("done",   d, 64'(o_done[d]), 64'(m_done[d]));
            check("error",  d, 64'(o_err[d]),  64'(m_err[d]));
            check("result", d, o_res[d],       m_res[d]);
        end
    end

    // Issues one request; poke>0 re-pulses start that many cycles in, while busy.
    task automatic run(input int d, input logic [63:0] m, input logic [63:0] e, input logic [63:0] n,
                       input bit with_abort, input int poke,
                       output logic [63:0] res, output logic err, output int lat);
        @(posedge clk); #2;
        s_msg[d] = m;  s_exp[d] = e;  s_mod[d] = n;
        s_start[d] = 1'b1;  s_abort[d] = with_abort;
        @(posedge clk); #2;
        s_start[d] = 1'b0;  s_abort[d] = 1'b0;
        s_msg[d] = ~m;  s_exp[d] = ~e;  s_mod[d] = 64'd0;
        lat = 0;
        while (lat < 9000) begin
            @(posedge clk);
            lat++;
            #1;
            s_start[d] = (lat == poke);
            if (o_done[d]) break;
        end
        s_start[d] = 1'b0;
        res = o_res[d];
        err = o_err[d];
        if (!o_done[d]) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout dut%0d: got no done, expected done within 9000 cycles", d);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish before 2000000");
        $fatal(1);
    end

    initial begin
        logic [63:0] res;
        logic        err;
        int          lat;
        bit          saw_done;
        logic [63:0] rm, re, rn;

        for (int d = 0; d < 3; d++) begin
            s_start[d] = 1'b0;  s_abort[d] = 1'b0;
            s_msg[d] = 64'd0;   s_exp[d] = 64'd0;  s_mod[d] = 64'd0;
        end
        #1 rst_n = 1'b0;
        #2;
        for (int d = 0; d < 3; d++) begin
            check("rst_busy", d, 64'(o_busy[d]), 64'd0);
            check("rst_done", d, 64'(o_done[d]), 64'd0);
            check("rst_err",  d, 64'(o_err[d]),  64'd0);
            check("rst_res",  d, o_res[d],       64'd0);
        end
        #20 rst_n = 1'b1;

        run(0, 8, 13, 77, 1'b0, 0, res, err, lat);
        check("ct_res", 0, res, 64'd50);  check("ct_err", 0, 64'(err), 64'd0);
        check("ct_lat", 0, 64'(lat), 64'd138);

        run(1, 8, 13, 77, 1'b0, 0, res, err, lat);
        check("vt_res", 1, res, 64'd50);  check("vt_lat", 1, 64'(lat), 64'd98);

        run(0, 50, 37, 77, 1'b0, 0, res, err, lat);
        check("rsa_dec", 0, res, 64'd8);  check("rsa_lat", 0, 64'(lat), 64'd138);
        run(0, 85, 1, 77, 1'b0, 0, res, err, lat);
        check("reduce_res", 0, res, 64'd8);
        run(1, 85, 1, 77, 1'b0, 0, res, err, lat);
        check("vt_reduce_res", 1, res, 64'd8);  check("vt_reduce_lat", 1, 64'(lat), 64'd82);

        run(0, 123, 0, 77, 1'b0, 0, res, err, lat);
        check("e0_res", 0, res, 64'd1);
        run(1, 123, 0, 77, 1'b0, 0, res, err, lat);
        check("vt_e0_res", 1, res, 64'd1);  check("vt_e0_lat", 1, 64'(lat), 64'd74);
        run(0, 123, 0, 1, 1'b0, 0, res, err, lat);
        check("m1_res", 0, res, 64'd0);  check("m1_err", 0, 64'(err), 64'd0);
        run(0, 5, 3, 0, 1'b0, 0, res, err, lat);
        check("m0_err", 0, 64'(err), 64'd1);  check("m0_res", 0, res, 64'd0);
        check("m0_lat", 0, 64'(lat), 64'd2);

        run(1, 8, 13, 77, 1'b1, 0, res, err, lat);
        check("abort_start_idle_res", 1, res, 64'd50);

        run(0, 8, 13, 77, 1'b0, 5, res, err, lat);
        check("poke_res", 0, res, 64'd50);  check("poke_lat", 0, 64'(lat), 64'd138);
        check("poke_err", 0, 64'(err), 64'd0);

        run(0, 85, 1, 77, 1'b0, 0, res, err, lat);
        @(posedge clk); #2;
        s_msg[0] = 50;  s_exp[0] = 37;  s_mod[0] = 77;  s_start[0] = 1'b1;
        @(posedge clk); #2;
        s_start[0] = 1'b0;
        repeat (12) @(posedge clk);
        #2 s_abort[0] = 1'b1;
        @(posedge clk); #1;
        s_abort[0] = 1'b0;
        check("abort_busy", 0, 64'(o_busy[0]), 64'd0);
        saw_done = 1'b0;
        repeat (150) begin
            @(posedge clk); #1;
            saw_done |= o_done[0];
        end
        check("abort_nodone", 0, 64'(saw_done), 64'd0);
        check("abort_hold", 0, o_res[0], 64'd8);

        run(0, 8, 13, 77, 1'b0, 0, res, err, lat);
        @(posedge clk); #2;
        s_msg[0] = 50;  s_exp[0] = 37;  s_mod[0] = 77;  s_start[0] = 1'b1;
        @(posedge clk); #2;
        s_start[0] = 1'b0;
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 0, 64'(o_busy[0]), 64'd0);
        check("mid_rst_done", 0, 64'(o_done[0]), 64'd0);
        check("mid_rst_err",  0, 64'(o_err[0]),  64'd0);
        check("mid_rst_res",  0, o_res[0],       64'd0);
        #10 rst_n = 1'b1;

        for (int k = 0; k < 5; k++) begin
            rm = {$urandom, $urandom};
            re = {$urandom, $urandom};
            rn = {$urandom, $urandom};
            if (rn == 64'd0) rn = 64'd1;
            run(2, rm, re, rn, 1'b0, 0, res, err, lat);
            check("w64_res", 2, res, ref_pow(rm, re, rn, 64));
            check("w64_lat", 2, 64'(lat), 64'd8258);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
